// File: rtl/idma_axis_rx_fifo.sv
// AXI-Stream receive FIFO (first-word-fall-through) with per-packet byte and packet counters.
// Latency: a push into an empty FIFO is visible on out_valid_o one cycle later; pkt_done_o pulses the cycle after a tlast push.
// Backpressure: axis_tready_o drops when full or flushing; a full FIFO never passes a beat through in the same cycle.
module idma_axis_rx_fifo #(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned StrbWidth = DataWidth / 8,
   parameter int unsigned Depth     = 8,
   parameter int unsigned CntWidth  = 32,
   localparam int unsigned AddrW    = $clog2(Depth),
   localparam int unsigned FillW    = $clog2(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic [DataWidth-1:0] axis_tdata_i,
   input  logic [StrbWidth-1:0] axis_tkeep_i,
   input  logic                 axis_tlast_i,
   input  logic                 axis_tvalid_i,
   output logic                 axis_tready_o,
   output logic [DataWidth-1:0] out_data_o,
   output logic [StrbWidth-1:0] out_keep_o,
   output logic                 out_last_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [FillW-1:0]     fill_o,
   output logic                 pkt_done_o,
   output logic [CntWidth-1:0]  pkt_bytes_o,
   output logic [CntWidth-1:0]  pkt_count_o,
   output logic                 busy_o
);

   typedef struct packed {
      logic [DataWidth-1:0] dat;
      logic [StrbWidth-1:0] keep;
      logic                 last;
   } entry_t;

   entry_t              mem_q [Depth];
   entry_t              head;
   logic [AddrW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [FillW-1:0]    fill_q, fill_d;
   logic [CntWidth-1:0] acc_q, acc_d, bytes_q, bytes_d, cnt_q, cnt_d;
   logic                in_pkt_q, in_pkt_d, done_q, done_d;
   logic                rdy_en_q;
   logic                push, pop, full, empty;
   logic [CntWidth:0]   acc_sum;
   logic [CntWidth-1:0] acc_sat;

   function automatic logic [CntWidth:0] popcnt(input logic [StrbWidth-1:0] k);
      logic [CntWidth:0] n;
      n = '0;
      for (int i = 0; i < StrbWidth; i++) n = n + {{CntWidth{1'b0}}, k[i]};
      return n;
   endfunction

   assign full  = (fill_q == FillW'(Depth));
   assign empty = (fill_q == '0);
   // rdy_en_q holds tready low through reset and until the first edge after release
   assign axis_tready_o = rdy_en_q && !full && !flush_i;
   assign out_valid_o   = !empty && !flush_i;
   assign push          = axis_tvalid_i && axis_tready_o;
   assign pop           = out_valid_o && out_ready_i;

   assign head       = mem_q[rd_q];
   assign out_data_o = head.dat;
   assign out_keep_o = head.keep;
   assign out_last_o = head.last;

   assign fill_o      = fill_q;
   assign pkt_done_o  = done_q;
   assign pkt_bytes_o = bytes_q;
   assign pkt_count_o = cnt_q;
   assign busy_o      = !empty || in_pkt_q;

   assign acc_sum = {1'b0, acc_q} + popcnt(axis_tkeep_i);
   assign acc_sat = acc_sum[CntWidth] ? '1 : acc_sum[CntWidth-1:0];

   always_comb begin
      wr_d     = wr_q;
      rd_d     = rd_q;
      fill_d   = fill_q;
      acc_d    = acc_q;
      bytes_d  = bytes_q;
      cnt_d    = cnt_q;
      in_pkt_d = in_pkt_q;
      done_d   = 1'b0;
      if (flush_i) begin
         wr_d     = '0;
         rd_d     = '0;
         fill_d   = '0;
         acc_d    = '0;
         in_pkt_d = 1'b0;
      end else begin
         if (push) begin
            wr_d = wr_q + AddrW'(1);
            if (axis_tlast_i) begin
               bytes_d  = acc_sat;
               acc_d    = '0;
               cnt_d    = cnt_q + CntWidth'(1);
               done_d   = 1'b1;
               in_pkt_d = 1'b0;
            end else begin
               acc_d    = acc_sat;
               in_pkt_d = 1'b1;
            end
         end
         if (pop) rd_d = rd_q + AddrW'(1);
         case ({push, pop})
            2'b10:   fill_d = fill_q + FillW'(1);
            2'b01:   fill_d = fill_q - FillW'(1);
            default: fill_d = fill_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q     <= '0;
         rd_q     <= '0;
         fill_q   <= '0;
         acc_q    <= '0;
         bytes_q  <= '0;
         cnt_q    <= '0;
         in_pkt_q <= 1'b0;
         done_q   <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         fill_q   <= fill_d;
         acc_q    <= acc_d;
         bytes_q  <= bytes_d;
         cnt_q    <= cnt_d;
         in_pkt_q <= in_pkt_d;
         done_q   <= done_d;
         rdy_en_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= '{dat: axis_tdata_i, keep: axis_tkeep_i, last: axis_tlast_i};
   end

endmodule
